avg_seq_ctrl: RTL

//  Sequencer for a shared 8-sample averaging datapath. It accepts one sample per

---
 rtl/avg_seq_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/avg_seq_ctrl.sv
// avg_seq_ctrl
//   Sequencer for a shared averaging datapath. It takes NUM_SAMPLES samples
//   through a valid/ready handshake and adds each one into a single
//   accumulator. It then shifts the sum right SHIFT_STEPS times, one pass per
//   cycle. The low DATAWIDTH bits of the accumulator are offered on a
//   valid/ready output.
//
// Ports
//   Clk        clock, rising edge
//   Rst        asynchronous reset, active low
//   abort      synchronous frame discard, active high, overrides everything
//   in_data    unsigned sample
//   in_valid   sample present
//   in_ready   sample accepted this cycle (only in ACCUM)
//   sh_amt     per-pass shift amount, captured on the last sample beat
//   out_avg    registered result (low bits of the accumulator)
//   out_valid  result present (DONE state)
//   out_ready  consumer takes the result
//   busy       a frame is in progress
module avg_seq_ctrl #(
  parameter int DATAWIDTH   = 16,
  parameter int ACCWIDTH    = 32,
  parameter int NUM_SAMPLES = 8,
  parameter int SHIFT_STEPS = 3
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 abort,
  input  logic [DATAWIDTH-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0]           sh_amt,
  output logic [DATAWIDTH-1:0] out_avg,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
);

  localparam int CNT_W  = $clog2(NUM_SAMPLES);
  localparam int STEP_W = (SHIFT_STEPS > 1) ? $clog2(SHIFT_STEPS) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(NUM_SAMPLES - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(SHIFT_STEPS - 1);

  localparam logic [1:0] ST_ACCUM = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]          state_q,  state_d;
  logic [ACCWIDTH-1:0] acc_q,    acc_d;
  logic [CNT_W-1:0]    cnt_q,    cnt_d;
  logic [STEP_W-1:0]   step_q,   step_d;
  logic [7:0]          sh_reg_q, sh_reg_d;
  logic                beat;

  // Logical right shift. Amounts at or beyond the accumulator width flush
  // to zero explicitly, so the result does not depend on how the tool treats
  // oversize shifts.
  function automatic logic [ACCWIDTH-1:0] shr_flush(
    input logic [ACCWIDTH-1:0] v,
    input logic [7:0]          amt
  );
    logic [ACCWIDTH-1:0] r;
    if (32'(amt) >= 32'(ACCWIDTH)) r = '0;
    else                           r = v >> amt;
    return r;
  endfunction

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    step_d   = step_q;
    sh_reg_d = sh_reg_q;

    in_ready  = (state_q == ST_ACCUM);
    out_valid = (state_q == ST_DONE);
    beat      = in_valid & in_ready;

    if (abort) begin
      // A discarded frame leaves nothing behind. A same-cycle input beat is
      // dropped. A same-cycle output handshake still counts for the consumer.
      acc_d   = '0;
      cnt_d   = '0;
      step_d  = '0;
      state_d = ST_ACCUM;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (beat) begin
            acc_d = acc_q + ACCWIDTH'(in_data);
            if (cnt_q == CNT_LAST) begin
              cnt_d    = '0;
              step_d   = '0;
              sh_reg_d = sh_amt;
              state_d  = ST_SHIFT;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          acc_d = shr_flush(acc_q, sh_reg_q);
          if (step_q == STEP_LAST) begin
            step_d  = '0;
            state_d = ST_DONE;
          end else begin
            step_d = step_q + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            acc_d   = '0;
            state_d = ST_ACCUM;
          end
        end
        default: state_d = ST_ACCUM;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= ST_ACCUM;
      acc_q    <= '0;
      cnt_q    <= '0;
      step_q   <= '0;
      sh_reg_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      step_q   <= step_d;
      sh_reg_q <= sh_reg_d;
    end
  end

  // The accumulator is the result register. It holds still in DONE.
  assign out_avg = acc_q[DATAWIDTH-1:0];
  assign busy    = (cnt_q != '0) || (state_q != ST_ACCUM);

endmodule
